frame_mem_arbiter: RTL and testbench

//  Shares the banked 8-bit frame memory between two requesters:
//  - the VGA scan-out reader, which has priority;
//  - the SIMD core, which can read and write.
//  The memory is NUM_BANKS single-port 64K x 8 RAMs behind one 19-bit flat address.

---
 rtl/frame_mem_arbiter_pkg.sv | 29 ++
 rtl/frame_mem_arbiter_if.sv | 39 +++
 rtl/frame_mem_arbiter_bank_dec.sv | 26 ++
 rtl/frame_mem_arbiter.sv | 110 +++++++++++
 tb/tb_frame_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_mem_arbiter_pkg.sv
// frame_mem_pkg: shared constants and types for the frame memory arbiter.
// No ports; imported by the interface, the bank decoder and the arbiter top.
package frame_mem_pkg;

  localparam int unsigned NUM_BANKS  = 5;
  localparam int unsigned BANK_AW    = 16;
  localparam int unsigned AW         = 19;
  localparam int unsigned DW         = 8;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned BANK_W     = AW - BANK_AW;
  localparam int unsigned STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef logic [BANK_W-1:0] bank_idx_t;

  // Which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  // Request actually issued to the memory in a cycle.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// frame_mem_arbiter_if: VGA, core and memory-side bus of the frame memory arbiter.
// slave modport : arbiter view (requests and mem_rdata in; acks, grants, read data, mem controls out).
// master modport: requesters/memory view (the mirror image).
interface frame_mem_arbiter_if;
  import frame_mem_pkg::*;

  logic                    vga_req;
  logic [AW-1:0]           vga_addr;
  logic                    vga_ack;
  logic                    vga_rvalid;
  logic [DW-1:0]           vga_rdata;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [AW-1:0]           cpu_addr;
  logic [DW-1:0]           cpu_wdata;
  logic                    cpu_gnt;
  logic                    cpu_rvalid;
  logic [DW-1:0]           cpu_rdata;
  logic                    cpu_err;

  logic [BANK_AW-1:0]      mem_addr;
  logic [DW-1:0]           mem_wdata;
  logic [NUM_BANKS-1:0]    mem_we;
  logic [NUM_BANKS*DW-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_ack, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_ack, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
           mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/frame_mem_arbiter_bank_dec.sv
// frame_mem_bank_dec: splits a flat frame address into bank index, one-hot bank
// select and local address, and flags addresses beyond the last bank.
// Ports: addr (flat in), bank, bank_oh, local_addr, in_range (all out, combinational).
module frame_mem_bank_dec
  import frame_mem_pkg::*;
(
  input  logic [AW-1:0]        addr,
  output bank_idx_t            bank,
  output logic [NUM_BANKS-1:0] bank_oh,
  output logic [BANK_AW-1:0]   local_addr,
  output logic                 in_range
);

  assign bank       = addr[AW-1:BANK_AW];
  assign local_addr = addr[BANK_AW-1:0];
  assign in_range   = (bank < BANK_W'(NUM_BANKS));

  // One-hot select; stays all-zero for out-of-range banks.
  always_comb begin
    bank_oh = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_oh[i] = (bank == BANK_W'(i));
    end
  end

endmodule

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the banked frame memory between the VGA reader
// (priority) and the SIMD core, with a starvation counter bounding core latency.
// Ports: clk, rst_n (synchronous, active low), bus (frame_mem_arbiter_if.slave)
// carrying the VGA request/return, core request/return and bank memory signals.
module frame_mem_arbiter
  import frame_mem_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  frame_mem_arbiter_if.slave  bus
);

  logic                 gnt_vga;
  logic                 gnt_cpu;
  mem_req_t             req;
  bank_idx_t            dec_bank;
  logic [NUM_BANKS-1:0] dec_oh;
  logic [BANK_AW-1:0]   dec_local;
  logic                 dec_in_range;

  logic [STARVE_W-1:0]  starve_cnt;
  owner_e               rd_owner;
  bank_idx_t            rd_bank;
  logic                 rd_in_range;
  logic [DW-1:0]        rd_slice;

  // Single grant per cycle: VGA wins unless the core has waited STARVE_MAX cycles.
  always_comb begin
    gnt_vga = 1'b0;
    gnt_cpu = 1'b0;
    if (rst_n) begin
      if (bus.cpu_req && (!bus.vga_req || starve_cnt == STARVE_W'(STARVE_MAX))) begin
        gnt_cpu = 1'b1;
      end else if (bus.vga_req) begin
        gnt_vga = 1'b1;
      end
    end
  end

  // Mux the granted request; all-zero when nobody is granted.
  always_comb begin
    req = '0;
    if (gnt_cpu) begin
      req = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
    end else if (gnt_vga) begin
      req = '{we: 1'b0, addr: bus.vga_addr, wdata: '0};
    end
  end

  frame_mem_bank_dec u_dec (
    .addr       (req.addr),
    .bank       (dec_bank),
    .bank_oh    (dec_oh),
    .local_addr (dec_local),
    .in_range   (dec_in_range)
  );

  assign bus.vga_ack   = gnt_vga;
  assign bus.cpu_gnt   = gnt_cpu;
  assign bus.mem_addr  = dec_local;
  assign bus.mem_wdata = req.wdata;
  assign bus.mem_we    = req.we ? dec_oh : '0;

  // Starvation counter and read-return tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt  <= '0;
      rd_owner    <= OWN_NONE;
      rd_bank     <= '0;
      rd_in_range <= 1'b0;
    end else begin
      if (bus.cpu_req && !gnt_cpu) begin
        if (starve_cnt != STARVE_W'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end else begin
        starve_cnt <= '0;
      end

      if (gnt_cpu && !bus.cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (gnt_vga) begin
        rd_owner <= OWN_VGA;
      end else begin
        rd_owner <= OWN_NONE;
      end
      rd_bank     <= dec_bank;
      rd_in_range <= dec_in_range;
    end
  end

  // Select the returning bank's q; out-of-range reads return zero.
  always_comb begin
    rd_slice = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (rd_in_range && rd_bank == BANK_W'(i)) begin
        rd_slice = bus.mem_rdata[i*DW +: DW];
      end
    end
  end

  // Return outputs are gated by rst_n so a read in flight at reset never surfaces.
  assign bus.vga_rvalid = rst_n && (rd_owner == OWN_VGA);
  assign bus.cpu_rvalid = rst_n && (rd_owner == OWN_CPU);
  assign bus.vga_rdata  = bus.vga_rvalid ? rd_slice : '0;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? rd_slice : '0;
  assign bus.cpu_err    = rst_n && ((gnt_cpu && bus.cpu_we && !dec_in_range) ||
                                    ((rd_owner == OWN_CPU) && !rd_in_range));

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and a flat memory image.
module tb_frame_mem_arbiter;
  import frame_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  frame_mem_arbiter_if bus();

  frame_mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank RAMs: one flat array, 1-cycle read latency on every bank.
  logic [DW-1:0]           ram [0:NUM_BANKS*65536-1];
  logic [NUM_BANKS*DW-1:0] ram_q;

  always @(posedge clk) begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (bus.mem_we[b]) ram[b*65536 + int'(bus.mem_addr)] <= bus.mem_wdata;
      ram_q[b*DW +: DW] <= ram[b*65536 + int'(bus.mem_addr)];
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference model state: who gets data next cycle, and what it must be.
  int            m_starve;
  int            m_own;      // 0 none, 1 vga, 2 cpu
  logic [DW-1:0] m_rdata;
  bit            m_rknown;
  bit            m_rerr;
  logic [DW-1:0] m_mem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs for this cycle, then advance the model across the clock edge.
  task automatic model_step();
    int   ga;
    int   bank;
    bit   inr;
    bit   gv;
    bit   gc;
    bit   rv_v;
    bit   rv_c;
    bit   e_err;
    logic [31:0] e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    gv = 1'b0;
    gc = 1'b0;
    if (rst_n) begin
      if (bus.cpu_req && (!bus.vga_req || m_starve >= int'(STARVE_MAX))) gc = 1'b1;
      else if (bus.vga_req) gv = 1'b1;
    end
    ga     = gc ? int'(bus.cpu_addr) : (gv ? int'(bus.vga_addr) : 0);
    bank   = ga / 65536;
    inr    = bank < int'(NUM_BANKS);
    e_we   = (gc && bus.cpu_we && inr) ? (32'd1 << bank) : 32'd0;
    e_addr = (gc || gv) ? 32'(ga % 65536) : 32'd0;
    e_wd   = gc ? 32'(bus.cpu_wdata) : 32'd0;
    rv_v   = rst_n && (m_own == 1);
    rv_c   = rst_n && (m_own == 2);
    e_err  = rst_n && ((gc && bus.cpu_we && !inr) || (m_own == 2 && m_rerr));

    chk("vga_ack",    32'(bus.vga_ack),    32'(gv));
    chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(gc));
    chk("mem_we",     32'(bus.mem_we),     e_we);
    chk("mem_addr",   32'(bus.mem_addr),   e_addr);
    chk("mem_wdata",  32'(bus.mem_wdata),  e_wd);
    chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(rv_v));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(rv_c));
    chk("cpu_err",    32'(bus.cpu_err),    32'(e_err));
    if (!rv_v) chk("vga_rdata_idle", 32'(bus.vga_rdata), 32'd0);
    else if (m_rknown) chk("vga_rdata", 32'(bus.vga_rdata), 32'(m_rdata));
    if (!rv_c) chk("cpu_rdata_idle", 32'(bus.cpu_rdata), 32'd0);
    else if (m_rknown) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));

    if (!rst_n) begin
      m_starve = 0;
      m_own    = 0;
    end else begin
      if (bus.cpu_req && !gc) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : m_starve;
      else m_starve = 0;
      m_own = 0;
      if (gv || (gc && !bus.cpu_we)) begin
        m_own    = gv ? 1 : 2;
        m_rerr   = !inr;
        m_rknown = !inr || m_mem.exists(ga);
        m_rdata  = !inr ? '0 : (m_mem.exists(ga) ? m_mem[ga] : '0);
      end
      if (gc && bus.cpu_we && inr) m_mem[ga] = bus.cpu_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    tick();
    chk("setup_wr_gnt", 32'(bus.cpu_gnt), 32'd1);
    adv();
    bus.cpu_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int b;
    int l;
    b = ($urandom % 8 == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
    l = ($urandom % 4 == 0) ? int'($urandom % 65536) : int'($urandom % 8);
    return AW'(b * 65536 + l);
  endfunction

  initial begin
    bit last_gnt;
    bit last_ack;
    total = 0;
    bad   = 0;
    m_starve = 0;
    m_own    = 0;
    m_rdata  = '0;
    m_rknown = 1'b0;
    m_rerr   = 1'b0;

    // Reset with both requesters active: everything must stay quiet.
    rst_n         = 1'b0;
    bus.vga_req   = 1'b1;
    bus.vga_addr  = '0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vga_ack", 32'(bus.vga_ack), 32'd0);
      chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
      adv();
    end

    // Release: VGA first, core forced in on the fifth contended cycle, then VGA again.
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("starve_vga_ack", 32'(bus.vga_ack), (k == 4) ? 32'd0 : 32'd1);
      chk("starve_cpu_gnt", 32'(bus.cpu_gnt), (k == 4) ? 32'd1 : 32'd0);
      adv();
    end
    idle();
    tick();
    adv();

    // Core write then read back through bank 1.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h10005;
    bus.cpu_wdata = 8'hA5;
    tick();
    chk("wr_gnt",      32'(bus.cpu_gnt),  32'd1);
    chk("wr_mem_we",   32'(bus.mem_we),   32'h02);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'h0005);
    adv();
    bus.cpu_we = 1'b0;
    tick();
    chk("rd_gnt", 32'(bus.cpu_gnt), 32'd1);
    adv();
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd_rdata",  32'(bus.cpu_rdata),  32'hA5);
    chk("rd_err",    32'(bus.cpu_err),    32'd0);
    adv();

    // Out-of-range core read and write.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 19'h50000;
    tick();
    chk("oor_rd_gnt",    32'(bus.cpu_gnt), 32'd1);
    chk("oor_rd_mem_we", 32'(bus.mem_we),  32'd0);
    chk("oor_rd_err_early", 32'(bus.cpu_err), 32'd0);
    adv();
    bus.cpu_req = 1'b0;
    tick();
    chk("oor_rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("oor_rd_rdata",  32'(bus.cpu_rdata),  32'h00);
    chk("oor_rd_err",    32'(bus.cpu_err),    32'd1);
    adv();
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 19'h60000;
    bus.cpu_wdata = 8'h77;
    tick();
    chk("oor_wr_err",    32'(bus.cpu_err), 32'd1);
    chk("oor_wr_mem_we", 32'(bus.mem_we),  32'd0);
    adv();
    bus.cpu_req = 1'b0;
    tick();
    chk("oor_wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    adv();

    // VGA back-to-back across the bank0/bank1 boundary.
    cpu_write(19'h0FFFF, 8'h3C);
    cpu_write(19'h10000, 8'hC3);
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h0FFFF;
    tick();
    chk("b2b_ack0", 32'(bus.vga_ack), 32'd1);
    adv();
    bus.vga_addr = 19'h10000;
    tick();
    chk("b2b_ack1",    32'(bus.vga_ack),    32'd1);
    chk("b2b_rvalid0", 32'(bus.vga_rvalid), 32'd1);
    chk("b2b_rdata0",  32'(bus.vga_rdata),  32'h3C);
    adv();
    bus.vga_req = 1'b0;
    tick();
    chk("b2b_rvalid1", 32'(bus.vga_rvalid), 32'd1);
    chk("b2b_rdata1",  32'(bus.vga_rdata),  32'hC3);
    adv();

    // Core write followed immediately by VGA read of the same address.
    cpu_write(19'h20010, 8'h5A);
    bus.vga_req  = 1'b1;
    bus.vga_addr = 19'h20010;
    tick();
    chk("order_ack", 32'(bus.vga_ack), 32'd1);
    adv();
    bus.vga_req = 1'b0;
    tick();
    chk("order_rdata", 32'(bus.vga_rdata), 32'h5A);
    adv();

    // Reset the cycle after a core read grant drops the return.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 19'h10005;
    tick();
    chk("rstrd_gnt", 32'(bus.cpu_gnt), 32'd1);
    adv();
    rst_n       = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    chk("rstrd_rvalid_in_rst", 32'(bus.cpu_rvalid), 32'd0);
    adv();
    rst_n = 1'b1;
    tick();
    chk("rstrd_rvalid_after", 32'(bus.cpu_rvalid), 32'd0);
    adv();

    // Randomized traffic honouring the hold-until-accepted rules.
    last_gnt = 1'b1;
    last_ack = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (!(bus.cpu_req && !last_gnt)) begin
        bus.cpu_req   = ($urandom % 3) != 0;
        bus.cpu_we    = ($urandom % 2) != 0;
        bus.cpu_addr  = rnd_addr();
        bus.cpu_wdata = DW'($urandom);
      end
      if (!(bus.vga_req && !last_ack)) begin
        bus.vga_req  = ($urandom % 2) != 0;
        bus.vga_addr = rnd_addr();
      end
      rst_n = ($urandom % 150) != 0;
      tick();
      last_gnt = bus.cpu_gnt;
      last_ack = bus.vga_ack;
      adv();
    end
    rst_n = 1'b1;
    idle();
    tick();
    adv();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
